// File: rtl/key_conditioner_if.sv
// Key bus between the board buttons, the key conditioner and the game logic.
// The slave side is the conditioner; the master side drives the raw pins.
interface key_conditioner_if #(
  parameter int KEYS_W = 4
);
  logic [KEYS_W-1:0] keys_raw_i;
  logic [KEYS_W-1:0] keys_o;
  logic [KEYS_W-1:0] press_o;
  logic [KEYS_W-1:0] release_o;

  modport slave  (input  keys_raw_i, output keys_o, press_o, release_o);
  modport master (output keys_raw_i, input  keys_o, press_o, release_o);
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces raw push-button pins into clean active-high levels,
// with one-cycle press/release pulses aligned to the level change.
module key_conditioner #(
  parameter int KEYS_W          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  key_conditioner_if.slave bus
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEYS_W-1:0] w_norm;
  logic [KEYS_W-1:0] w_flip;
  logic [KEYS_W-1:0] r_sync1;
  logic [KEYS_W-1:0] r_sync2;
  logic [KEYS_W-1:0] r_stable;
  logic [KEYS_W-1:0] r_press;
  logic [KEYS_W-1:0] r_release;
  logic [CNT_W-1:0]  r_cnt [KEYS_W];

  assign w_norm = (KEY_ACTIVE_LOW != 0) ? ~bus.keys_raw_i : bus.keys_raw_i;

  // Two-stage synchroniser; reset value 0 is the released level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
    end
  end

  // A key flips on the edge where it has already differed for DEBOUNCE_CYCLES-1 edges.
  always_comb begin
    w_flip = '0;
    for (int k = 0; k < KEYS_W; k++) begin
      w_flip[k] = (r_sync2[k] != r_stable[k]) && (r_cnt[k] == CNT_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < KEYS_W; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < KEYS_W; k++) begin
        if ((r_sync2[k] == r_stable[k]) || w_flip[k]) begin
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Pulses are registered on the same edge as the level so they line up with keys_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_stable  <= r_stable ^ w_flip;
      r_press   <= w_flip & r_sync2;
      r_release <= w_flip & ~r_sync2;
    end
  end

  assign bus.keys_o    = r_stable;
  assign bus.press_o   = r_press;
  assign bus.release_o = r_release;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: stimulus queues expected output events,
// a negedge monitor pops and compares them whenever the outputs change or pulse.
module tb_key_conditioner;

  typedef struct {
    int         cyc;
    logic [3:0] keys;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  logic [3:0] prev_keys;
  ev_t  exp_q[$];

  key_conditioner_if #(.KEYS_W(4)) bus ();

  key_conditioner #(
    .KEYS_W          (4),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [3:0] k, input logic [3:0] p,
                           input logic [3:0] r);
    ev_t e;
    e.cyc = c; e.keys = k; e.press = p; e.rel = r;
    exp_q.push_back(e);
  endtask

  // Drive v just after an edge; it is then sampled on n consecutive edges.
  task automatic step(input logic [3:0] v, input int n, output int c);
    @(posedge clk);
    #1 bus.keys_raw_i = v;
    c = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  // Monitor: any pulse or level change is an event that must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (bus.press_o != 4'b0 || bus.release_o != 4'b0 || bus.keys_o != prev_keys) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: cyc=%0d keys=%b press=%b rel=%b, required no event",
                   cyc, bus.keys_o, bus.press_o, bus.release_o);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_cycle: actual=%0d required=%0d", cyc, e.cyc);
          end
          checks++;
          if ({bus.keys_o, bus.press_o, bus.release_o} !== {e.keys, e.press, e.rel}) begin
            errors++;
            $display("FAIL event_value at cyc %0d: actual keys=%b press=%b rel=%b required keys=%b press=%b rel=%b",
                     cyc, bus.keys_o, bus.press_o, bus.release_o, e.keys, e.press, e.rel);
          end
        end
      end
      prev_keys = bus.keys_o;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int i;
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0; prev_keys = 4'b0;
    bus.keys_raw_i = 4'hF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    idle(3);
    mon_en = 1'b1;
    #1 rst_n = 1'b1;
    idle(8);
    chk("reset_exit_keys", bus.keys_o, 4'b0);
    chk("reset_exit_press", bus.press_o, 4'b0);
    chk("reset_exit_release", bus.release_o, 4'b0);

    // Clean press and release of key 0
    step(4'b1110, 1, c); expect_ev(c + 6, 4'b0001, 4'b0001, 4'b0000); idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b0001); idle(10);

    // Key 1 bounces with 3-cycle pressed runs, then holds
    step(4'b1101, 3, c);
    step(4'b1111, 1, c);
    step(4'b1101, 3, c);
    step(4'b1111, 1, c);
    step(4'b1101, 1, c); expect_ev(c + 6, 4'b0010, 4'b0010, 4'b0000); idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b0010); idle(10);

    // Key 2 press then release pulse
    step(4'b1011, 1, c); expect_ev(c + 6, 4'b0100, 4'b0100, 4'b0000); idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b0100); idle(10);

    // Keys 0 and 3 together while key 1 chatters
    step(4'b0110, 1, c); expect_ev(c + 6, 4'b1001, 4'b1001, 4'b0000);
    for (i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 bus.keys_raw_i = (i % 2 == 0) ? 4'b0100 : 4'b0110;
    end
    idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b1001); idle(10);

    // Asynchronous reset with key 2 held, then held through reset release
    step(4'b1011, 1, c); expect_ev(c + 6, 4'b0100, 4'b0100, 4'b0000); idle(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_ev(cyc, 4'b0000, 4'b0000, 4'b0000);
    #1;
    chk("async_reset_keys", bus.keys_o, 4'b0);
    chk("async_reset_press", bus.press_o, 4'b0);
    chk("async_reset_release", bus.release_o, 4'b0);
    idle(2);
    #1 rst_n = 1'b1;
    expect_ev(cyc + 6, 4'b0100, 4'b0100, 4'b0000);
    idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b0100); idle(10);

    // Reset in the middle of key 0 debounce discards the partial count
    step(4'b1110, 1, c);
    idle(3);
    #2 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    expect_ev(cyc + 6, 4'b0001, 4'b0001, 4'b0000);
    idle(10);
    step(4'b1111, 1, c); expect_ev(c + 6, 4'b0000, 4'b0000, 4'b0001); idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: actual=%0d pending required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
